// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state type and helpers for the configurable sequence detector
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HUNT} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
  function automatic logic [31:0] len_mask(input int len);
    return (len >= 32) ? '1 : (32'd1 << len) - 32'd1;
  endfunction
endpackage

// File: rtl/seq_det_match.sv
// seq_det_match: masked compare of recent history plus the incoming bit against the pattern
module seq_det_match import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic [MAX_LEN-2:0] hist,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  logic [MAX_LEN-1:0] mask;
  assign mask = MAX_LEN'(len_mask(int'(len)));
  assign hit = ~|(({hist, bit_in} ^ pattern) & mask);
endmodule

// File: rtl/seq_det_cfg.sv
// seq_det_cfg: runtime-configurable serial sequence detector with overlap control and match counter
module seq_det_cfg import seq_det_pkg::*; #(
  parameter int MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 'b101,
  parameter int DEF_LEN = 3,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         bit_in,
  input  logic                         overlap,
  input  logic                         cfg_we,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cnt_clr,
  output logic                         det,
  output logic                         det_r,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cfg_err
);
  localparam int LEN_W = len_w(MAX_LEN);
  state_t state;
  logic [MAX_LEN-2:0] hist;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0] len, fill, fill_nx;
  logic hit, acc, cfg_bad;
  seq_det_match #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
    .hist(hist), .bit_in(bit_in), .pattern(pattern), .len(len), .hit(hit)
  );
  assign acc = en & in_valid;
  assign det = ~rst & acc & (state == HUNT) & hit;
  assign cfg_bad = en | (cfg_len < LEN_W'(2)) | (cfg_len > LEN_W'(MAX_LEN));
  // fill never needs to exceed len-1: that alone is enough to arm HUNT
  assign fill_nx = (fill == len - LEN_W'(1)) ? fill : fill + LEN_W'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern   <= DEF_PATTERN;
      len       <= LEN_W'(DEF_LEN);
      state     <= IDLE;
      hist      <= '0;
      fill      <= '0;
      det_r     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      det_r     <= det;
      cfg_err   <= cfg_we & cfg_bad;
      match_cnt <= cnt_clr ? '0 : (det & ~&match_cnt) ? match_cnt + CNT_W'(1) : match_cnt;
      if (cfg_we & ~cfg_bad) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
      end
      if (~en) begin
        state <= IDLE;
        hist  <= '0;
        fill  <= '0;
      end else if (acc) begin
        hist <= (MAX_LEN-1)'({hist, bit_in});
        if (det & ~overlap) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill  <= fill_nx;
          state <= (fill_nx == len - LEN_W'(1)) ? HUNT : FILL;
        end
      end else if (state == IDLE) begin
        state <= FILL;
      end
    end
  end
endmodule
